// File: rtl/rf_pkg.sv
`default_nettype none
// =============================================================================
// Module      : rf_pkg
// Description : Shared defaults and fixed register indices for regfile_sb.
// Revision    : 1.0 - initial release
// =============================================================================
package rf_pkg;

    localparam int          XLEN_DEF    = 32;
    localparam int          NREG_DEF    = 32;
    localparam int          NRD_DEF     = 2;

    localparam int          SP_IDX      = 2;
    localparam int          GP_IDX      = 3;

    localparam logic [31:0] SP_INIT_DEF = 32'h0000_2ffc;
    localparam logic [31:0] GP_INIT_DEF = 32'h0000_1800;

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// =============================================================================
// Module      : rf_scoreboard
// Description : Per-register write-pending bits, set at issue and cleared at
//               writeback, with a same-cycle writeback bypass on each read port.
// Revision    : 1.0 - initial release
// =============================================================================
module rf_scoreboard #(
    parameter  int NREG = 32,
    parameter  int NRD  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              iss,
    input  logic [AW-1:0]     ia,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD-1:0]    rbusy
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    // Set is applied after clear: a newer producer outranks this writeback.
    always_comb begin
        w_busy_nxt = r_busy;
        if (we && (wa != '0)) begin
            w_busy_nxt[wa] = 1'b0;
        end
        if (iss && (ia != '0)) begin
            w_busy_nxt[ia] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rbusy
        logic [AW-1:0] w_a;
        logic          w_b;

        assign w_a = ra[g*AW +: AW];

        always_comb begin
            w_b = r_busy[w_a];
            if (w_a == '0) begin
                w_b = 1'b0;
            end else if (we && (wa == w_a) && !(iss && (ia == w_a))) begin
                w_b = 1'b0;
            end
        end

        assign rbusy[g] = w_b;
    end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// =============================================================================
// Module      : regfile_sb
// Description : Multi-port integer register file with write-first bypass,
//               hardwired x0, programmable sp/gp reset values and an
//               integrated write-pending scoreboard.
//               Optional debug read port enabled by defining RF_DBG_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module regfile_sb
    import rf_pkg::*;
#(
    parameter  int              XLEN    = XLEN_DEF,
    parameter  int              NREG    = NREG_DEF,
    parameter  int              NRD     = NRD_DEF,
    parameter  logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEF),
    parameter  logic [XLEN-1:0] GP_INIT = XLEN'(GP_INIT_DEF),
    localparam int              AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rbusy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                iss,
`ifdef RF_DBG_EN
    input  logic [AW-1:0]       ra_dbg,
    output logic [XLEN-1:0]     rd_dbg,
`endif
    input  logic [AW-1:0]       ia
);

    logic [XLEN-1:0] r_regs [NREG];
    logic            w_we;

    // Reads must show reset contents while rstn is held low.
    assign w_we = we & rstn;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                if (i == SP_IDX) begin
                    r_regs[i] <= SP_INIT;
                end else if (i == GP_IDX) begin
                    r_regs[i] <= GP_INIT;
                end else begin
                    r_regs[i] <= '0;
                end
            end
        end else if (we && (wa != '0)) begin
            r_regs[wa] <= wd;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   w_a;
        logic [XLEN-1:0] w_d;

        assign w_a = ra[g*AW +: AW];

        always_comb begin
            w_d = r_regs[w_a];
            if (w_a == '0) begin
                w_d = '0;
            end else if (w_we && (wa == w_a)) begin
                w_d = wd;
            end
        end

        assign rd[g*XLEN +: XLEN] = w_d;
    end

`ifdef RF_DBG_EN
    logic [XLEN-1:0] w_dbg;

    always_comb begin
        w_dbg = r_regs[ra_dbg];
        if (ra_dbg == '0) begin
            w_dbg = '0;
        end else if (w_we && (wa == ra_dbg)) begin
            w_dbg = wd;
        end
    end

    assign rd_dbg = w_dbg;
`endif

    rf_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD)
    ) u_sb (
        .clk   (clk),
        .rstn  (rstn),
        .iss   (iss),
        .ia    (ia),
        .we    (we),
        .wa    (wa),
        .ra    (ra),
        .rbusy (rbusy)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// =============================================================================
// Module      : tb_regfile_sb
// Description : Self-checking bench for regfile_sb with a reference model and
//               an expected-result queue.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk  = 1'b0;
    logic                rstn = 1'b0;
    logic [NRD*AW-1:0]   ra   = '0;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rbusy;
    logic                we   = 1'b0;
    logic [AW-1:0]       wa   = '0;
    logic [XLEN-1:0]     wd   = '0;
    logic                iss  = 1'b0;
    logic [AW-1:0]       ia   = '0;
`ifdef RF_DBG_EN
    logic [AW-1:0]       ra_dbg = '0;
    logic [XLEN-1:0]     rd_dbg;
`endif

    always #5 clk = ~clk;

    regfile_sb u_dut (
        .clk    (clk),
        .rstn   (rstn),
        .ra     (ra),
        .rd     (rd),
        .rbusy  (rbusy),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .iss    (iss),
`ifdef RF_DBG_EN
        .ra_dbg (ra_dbg),
        .rd_dbg (rd_dbg),
`endif
        .ia     (ia)
    );

    typedef struct {
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [31:0] dbg;
        logic        rb0;
        logic        rb1;
    } exp_t;

    exp_t        q_exp[$];
    logic [31:0] m_regs [NREG];
    bit          m_busy [NREG];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = (i == 2) ? 32'h2ffc : (i == 3) ? 32'h1800 : 32'h0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic logic [31:0] m_rd(input logic [AW-1:0] a, input bit we_e,
                                         input logic [AW-1:0] wa_i, input logic [31:0] wd_i);
        if (a == 0)               return 32'h0;
        if (we_e && (wa_i == a))  return wd_i;
        return m_regs[a];
    endfunction

    function automatic logic m_rb(input logic [AW-1:0] a, input bit we_e, input logic [AW-1:0] wa_i,
                                  input bit iss_e, input logic [AW-1:0] ia_i);
        if (a == 0) return 1'b0;
        if (we_e && (wa_i == a) && !(iss_e && (ia_i == a))) return 1'b0;
        return m_busy[a];
    endfunction

    // One cycle: drive after the edge, predict, sample before the next edge.
    task automatic step(input bit rlo, input bit we_i, input logic [AW-1:0] wa_i,
                        input logic [31:0] wd_i, input bit iss_i, input logic [AW-1:0] ia_i,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] ad);
        exp_t e;
        exp_t got;
        bit   we_e;
        bit   iss_e;
        @(posedge clk);
        #1;
        rstn = !rlo;
        we   = we_i;
        wa   = wa_i;
        wd   = wd_i;
        iss  = iss_i;
        ia   = ia_i;
        ra   = {a1, a0};
`ifdef RF_DBG_EN
        ra_dbg = ad;
`endif
        if (rlo) m_reset();
        we_e   = we_i && !rlo;
        iss_e  = iss_i && !rlo;
        e.rd0  = m_rd(a0, we_e, wa_i, wd_i);
        e.rd1  = m_rd(a1, we_e, wa_i, wd_i);
        e.dbg  = m_rd(ad, we_e, wa_i, wd_i);
        e.rb0  = m_rb(a0, we_e, wa_i, iss_e, ia_i);
        e.rb1  = m_rb(a1, we_e, wa_i, iss_e, ia_i);
        q_exp.push_back(e);
        #3;
        if (q_exp.size() == 0) begin
            check_val("queue_empty", 32'h0, 32'h1);
        end else begin
            got = q_exp.pop_front();
            check_val($sformatf("rd0[x%0d]", a0), rd[31:0], got.rd0);
            check_val($sformatf("rd1[x%0d]", a1), rd[63:32], got.rd1);
            check_val($sformatf("rbusy0[x%0d]", a0), {31'h0, rbusy[0]}, {31'h0, got.rb0});
            check_val($sformatf("rbusy1[x%0d]", a1), {31'h0, rbusy[1]}, {31'h0, got.rb1});
`ifdef RF_DBG_EN
            check_val($sformatf("rd_dbg[x%0d]", ad), rd_dbg, got.dbg);
`endif
        end
        if (!rlo) begin
            if (iss_e && (ia_i != 0)) m_busy[ia_i] = 1'b1;
            if (we_e && (wa_i != 0)) begin
                m_regs[wa_i] = wd_i;
                if (!(iss_e && (ia_i == wa_i))) m_busy[wa_i] = 1'b0;
            end
        end
    endtask

    task automatic rand_steps(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        m_reset();
        // Reset with write/issue attempts that must be ignored
        step(1'b1, 1'b1, 5'd2, 32'hffff_ffff, 1'b1, 5'd5, 5'd2, 5'd3, 5'd3);
        step(1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd5, 5'd2, 5'd3);
        // x0 hardwired
        step(1'b0, 1'b1, 5'd0, 32'hdeadbeef,  1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 5'd2, 5'd0);
        // write-first bypass then storage
        step(1'b0, 1'b1, 5'd7, 32'h1234,      1'b0, 5'd0, 5'd3, 5'd7, 5'd7);
        step(1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd7, 5'd3, 5'd7);
        // scoreboard set at issue, cleared at writeback
        step(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 5'd9, 5'd9, 5'd9);
        step(1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd9, 5'd1, 5'd9);
        step(1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd1, 5'd9, 5'd9);
        step(1'b0, 1'b1, 5'd9, 32'ha5a5_a5a5, 1'b0, 5'd0, 5'd9, 5'd9, 5'd9);
        step(1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd9, 5'd9, 5'd9);
        // set wins over clear on the same register
        step(1'b0, 1'b1, 5'd4, 32'h55,        1'b1, 5'd4, 5'd4, 5'd4, 5'd4);
        step(1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd4, 5'd4, 5'd4);
        step(1'b0, 1'b1, 5'd4, 32'h66,        1'b0, 5'd0, 5'd4, 5'd0, 5'd4);
        // repeat issue and writeback to a non-busy register
        step(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd6, 5'd6, 5'd6, 5'd6);
        step(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd6, 5'd6, 5'd31, 5'd6);
        step(1'b0, 1'b1, 5'd31, 32'h3131,     1'b0, 5'd0, 5'd6, 5'd31, 5'd31);
        step(1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd31, 5'd6, 5'd31);
        rand_steps(60);
        // mid-run asynchronous reset
        step(1'b0, 1'b1, 5'd5, 32'h5555,      1'b1, 5'd2, 5'd5, 5'd2, 5'd5);
        step(1'b1, 1'b1, 5'd2, 32'hffff,      1'b1, 5'd5, 5'd2, 5'd5, 5'd3);
        step(1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd3, 5'd5, 5'd3);
        step(1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd2, 5'd3, 5'd3);
        rand_steps(30);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port integer register file with an integrated write-pending scoreboard, for the pipelined CPU datapath. It offers NRD combinational read ports and a debug read port, all with write-first bypass. Register x0 is hardwired to zero, and sp/gp take programmable reset values. Per-register busy bits are set at issue and cleared at writeback, so the hazard unit can stall on in-flight producers.

## Interface
- XLEN, 32, data width
- NREG, 32, register count (power of two, ≥2); AW = clog2(NREG)
- NRD, 2, read-port count (1..4)
- SP_INIT, 32'h2ffc, reset value of x2
- GP_INIT, 32'h1800, reset value of x3
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- ra  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
- rd  out  NRD*XLEN  read data, packed the same way as ra
- rbusy  out  NRD  busy bit of each read port's register, after bypass
- we  in  1  writeback enable
- wa  in  AW  writeback address
- wd  in  XLEN  writeback data
- iss  in  1  issue strobe: a producer for register ia is now in flight
- ia  in  AW  issue destination address
- ra_dbg  in  AW  debug read address (present only with RF_DBG_EN)
- rd_dbg  out  XLEN  debug read data (present only with RF_DBG_EN)

## Operation
- Storage is NREG×XLEN flops. x0 is never written and always reads 0.
- Write: at posedge clk, if we and wa≠0, then regs[wa] ← wd.
- Read (combinational, per port i):
  - ra_i = 0 → rd_i = 0.
  - we && wa = ra_i → rd_i = wd (write-first bypass).
  - Otherwise → rd_i = regs[ra_i].
- Scoreboard: busy[NREG], busy[0] permanently 0. At posedge:
  - iss && ia≠0 → busy[ia] ← 1.
  - we && wa≠0 → busy[wa] ← 0.
  - iss && we && ia = wa ≠ 0 → set wins; busy stays 1 because a newer producer was issued.
- rbusy_i = busy[ra_i], except it reads 0 when we && wa = ra_i && !(iss && ia = ra_i). The writeback in this cycle satisfies the reader.
- A writeback to a non-busy register is legal: data is written and busy stays 0.
- A repeat issue to an already-busy register is legal: it stays busy. There is no counting, so the consumer must serialise same-destination producers.
- Reset (rstn low, any time, including mid-operation):
  - all regs ← 0, except x2 ← SP_INIT and x3 ← GP_INIT.
  - all busy ← 0.
  - Outputs follow combinationally: rd/rd_dbg give the reset contents, and rbusy = 0.
- While rstn is low, we and iss are ignored.

## Timing
- Read latency: 0 cycles (combinational from ra, we, wa, wd).
- Write latency: data is visible through the bypass in the same cycle, and from storage from the next cycle.
- Busy set by iss in cycle n is visible on rbusy from cycle n+1.
- Busy clear is visible in cycle n through the bypass, and from storage from cycle n+1.
- Reset assertion is asynchronous. Deassertion is released synchronously by the upstream reset synchroniser; the first write can occur at the first posedge with rstn high.

## Configuration
- RF_DBG_EN defined: ra_dbg and rd_dbg exist, with the same x0 and bypass rules as the ports in rd. The debug port does not affect the scoreboard.
- RF_DBG_EN undefined: ra_dbg and rd_dbg are absent and no debug mux is built.

## Structure
- Shared package rf_pkg holds:
  - the default XLEN, NREG and NRD;
  - SP_IDX = 2, GP_IDX = 3;
  - the default SP_INIT and GP_INIT.
- Sub-module rf_scoreboard (parameters NREG, NRD) owns the busy vector, the set/clear priority and the rbusy bypass. The top holds the storage and data read muxes.

## Test plan
- Reset: pulse rstn low mid-run → rd gives x2 = 32'h2ffc, x3 = 32'h1800, x5 = 0; rbusy = 0 on every port.
- x0: we = 1, wa = 0, wd = 32'hdeadbeef, ra0 = 0 → rd0 = 0 in the same cycle and all later cycles.
- Bypass: we = 1, wa = 7, wd = 32'h1234, ra1 = 7 → rd1 = 32'h1234 in the same cycle; regs[7] = 32'h1234 after the edge with we low.
- Scoreboard: iss, ia = 9 at cycle 0 → rbusy = 1 for ra = 9 at cycle 1; we, wa = 9 at cycle 3 → rbusy = 0 at cycle 3 and after.
- Set-vs-clear: iss, ia = 4 and we, wa = 4 in the same cycle → rbusy for 4 is 1 in the next cycle, and data holds wd.
- NRD = 4 with RF_DBG_EN: four distinct ra plus ra_dbg = 3 → each port returns its own register, and rd_dbg = 32'h1800 after reset.
